wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be as follows:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- aluValid  in  1  ALU writeback request
- aluAddress  in  5  ALU destination register
- aluData  in  32  ALU result
- aluReady  out  1  ALU request accepted this cycle when aluValid=1
- lsuValid  in  1  load-return request
- lsuAddress  in  5  load destination register
- lsuData  in  32  load data
- lsuReady  out  1  load buffer can accept
- writeEnable  out  1  to the register file write port
- writeAddress  out  5  to the register file write port
- writeData  out  32  to the register file write port
- pendingMask  out  32  bit i=1: a buffered load targets register i
- loadCount  out  2  load-buffer occupancy, 0..2

Function
REQ-003 A handshake SHALL complete on any cycle where valid=1 and ready=1 on the same port; the payload is sampled only on that cycle.
REQ-004 Load returns SHALL always enter a 2-entry FIFO; they SHALL never write directly from the lsu inputs.
REQ-005 lsuReady SHALL equal (loadCount != 2) from registered state; the FIFO therefore never overflows.
REQ-006 Grant selection each cycle:
- The FIFO head SHALL win if loadCount==2 or waitCount==3.
- Otherwise the ALU SHALL win if aluValid=1.
- Otherwise the head SHALL win if loadCount!=0.
- Otherwise there is no grant.
REQ-007 aluReady SHALL equal !(loadCount==2 || waitCount==3); aluReady SHALL be 1 when idle.
REQ-008 waitCount (2-bit, internal) SHALL increment, saturating at 3, on each cycle the FIFO is non-empty and the head is not granted, and SHALL clear on head grant or when the FIFO is empty.
REQ-009 The write port outputs SHALL be registered: a grant in cycle N drives writeEnable/writeAddress/writeData in cycle N+1. With no grant in cycle N, writeEnable SHALL be 0 in cycle N+1.
REQ-010 Latency SHALL be:
- ALU accepted in cycle N, uncontested: written in cycle N+1.
- Load accepted in cycle N into an empty FIFO with no ALU contention: written in cycle N+2.
REQ-011 A granted request with address 0 SHALL be consumed (popped/acknowledged) and SHALL produce writeEnable=0; writeAddress and writeData are then don't-care.
REQ-012 A push and a pop in the same cycle SHALL both take effect. loadCount SHALL be unchanged, and FIFO order SHALL be preserved (oldest first).
REQ-013 pendingMask SHALL be combinational from FIFO contents: the OR over valid entries of the one-hot of each entry address, with bit 0 forced to 0. An entry's bit SHALL clear in the cycle after its pop.
REQ-014 At most one register-file write SHALL occur per cycle; no accepted request SHALL be lost or duplicated.
REQ-015 Two FIFO entries with the same address SHALL both be written, in order; the last write wins.

Reset
REQ-016 While reset=1 at a rising edge, the block SHALL set:
- writeEnable=0, writeAddress=0, writeData=0
- loadCount=0, waitCount=0, FIFO pointers=0
REQ-017 During reset, lsuReady and aluReady SHALL reflect the reset state. Handshakes coincident with reset SHALL be discarded.
REQ-018 Reset mid-operation SHALL drop buffered loads. pendingMask SHALL read 0 in the cycle after reset.

Structure
REQ-019 The following SHALL live in the shared core package: the register-address width (5), the data width (32), and the load-buffer depth constant (2).
REQ-020 The FIFO SHALL be a sub-module, wb_load_fifo (depth 2, push/pop/count/entry-view outputs). The grant logic, waitCount and output registers SHALL live in wb_arbiter.

Verification
REQ-021 Bench scenarios:
- ALU-only: aluValid with addr 5, data 0x0000_00AA, in cycle 0 -> aluReady=1; next cycle writeEnable=1, writeAddress=5, writeData=0xAA.
- Load-only: lsu addr 7, data 0xDEAD_BEEF, in cycle 0 -> pendingMask=0x80 in cycle 1; write in cycle 2; pendingMask=0 in cycle 3.
- Starvation: aluValid held continuously, one load to addr 3 in cycle 0 -> ALU wins cycles 1-3, aluReady=0 in cycle 4, load written in cycle 5, waitCount cleared.
- Full buffer: two loads (addr 1, 2) back-to-back while ALU is busy -> loadCount=2, lsuReady=0, aluReady=0; head (addr 1) is written first, then lsuReady=1.
- x0 writes: an ALU write to addr 0, then a load to addr 0 -> both consumed, writeEnable stays 0, pendingMask stays 0.
- Reset mid-op: loadCount=2, reset pulsed for one cycle -> all outputs 0, loadCount=0, and no later write of the dropped loads.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared core constants and types for the register-file writeback arbiter.
package wb_arbiter_pkg;

    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LOAD_DEPTH = 2;
    localparam int unsigned LOAD_PTR_W = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;
    localparam int unsigned CNT_W      = $clog2(LOAD_DEPTH + 1);
    localparam int unsigned WAIT_W     = 2;
    localparam int unsigned NUM_REGS   = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_ALU  = 2'd1,
        GRANT_LOAD = 2'd2
    } grant_e;

    // One-hot register select used to build the pending-load mask.
    function automatic logic [NUM_REGS-1:0] addr_onehot(input reg_addr_t addr);
        return NUM_REGS'(1) << addr;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: ALU and load-return request ports plus the register-file write port.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic                   aluValid;
    reg_addr_t              aluAddress;
    reg_data_t              aluData;
    logic                   aluReady;
    logic                   lsuValid;
    reg_addr_t              lsuAddress;
    reg_data_t              lsuData;
    logic                   lsuReady;
    logic                   writeEnable;
    reg_addr_t              writeAddress;
    reg_data_t              writeData;
    logic [NUM_REGS-1:0]    pendingMask;
    logic [CNT_W-1:0]       loadCount;

    modport slave (
        input  aluValid, aluAddress, aluData,
        input  lsuValid, lsuAddress, lsuData,
        output aluReady, lsuReady,
        output writeEnable, writeAddress, writeData,
        output pendingMask, loadCount
    );

    modport master (
        output aluValid, aluAddress, aluData,
        output lsuValid, lsuAddress, lsuData,
        input  aluReady, lsuReady,
        input  writeEnable, writeAddress, writeData,
        input  pendingMask, loadCount
    );

endinterface

// File: rtl/wb_load_fifo.sv
// Small in-order load-return buffer with per-entry views for hazard tracking.
module wb_load_fifo
    import wb_arbiter_pkg::*;
(
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  wb_req_t                        push_data_i,
    input  logic                           pop_i,
    output wb_req_t                        head_o,
    output logic [CNT_W-1:0]               count_o,
    output logic [LOAD_DEPTH-1:0]          entry_valid_o,
    output reg_addr_t [LOAD_DEPTH-1:0]     entry_addr_o
);

    logic [LOAD_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOAD_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    wb_req_t               mem_q [LOAD_DEPTH];
    logic                  push_ok;
    logic                  pop_ok;

    assign push_ok = push_i && (count_q != CNT_W'(LOAD_DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);

    // Pointer and occupancy update; push and pop in one cycle leave the count unchanged.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == LOAD_PTR_W'(LOAD_DEPTH - 1)) ? '0 : wr_ptr_q + LOAD_PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LOAD_PTR_W'(LOAD_DEPTH - 1)) ? '0 : rd_ptr_q + LOAD_PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; validity comes from the count and read pointer.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Slot i is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        for (int unsigned i = 0; i < LOAD_DEPTH; i++) begin
            entry_valid_o[i] = (CNT_W'(LOAD_PTR_W'(i) - rd_ptr_q) < count_q);
            entry_addr_o[i]  = mem_q[i].addr;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates ALU results and buffered load returns onto one register-file write port.
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    wb_arbiter_if.slave   bus
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    wb_req_t                    fifo_head;
    wb_req_t                    lsu_req;
    logic [CNT_W-1:0]           load_count;
    logic [LOAD_DEPTH-1:0]      entry_valid;
    reg_addr_t [LOAD_DEPTH-1:0] entry_addr;

    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       force_head;
    logic                       alu_ready;
    logic                       lsu_ready;
    logic                       lsu_push;
    logic                       head_pop;
    grant_e                     grant;

    logic [WAIT_W-1:0]          wait_q, wait_d;
    logic                       we_q, we_d;
    reg_addr_t                  waddr_q, waddr_d;
    reg_data_t                  wdata_q, wdata_d;
    logic [NUM_REGS-1:0]        pending_mask;

    assign lsu_req  = '{addr: bus.lsuAddress, data: bus.lsuData};
    assign lsu_push = bus.lsuValid && lsu_ready;
    assign head_pop = (grant == GRANT_LOAD);

    wb_load_fifo u_load_fifo (
        .clk_i         (clock),
        .rst_i         (reset),
        .push_i        (lsu_push),
        .push_data_i   (lsu_req),
        .pop_i         (head_pop),
        .head_o        (fifo_head),
        .count_o       (load_count),
        .entry_valid_o (entry_valid),
        .entry_addr_o  (entry_addr)
    );

    // Grant selection: a full buffer or a starved head preempts the ALU.
    always_comb begin
        fifo_full  = (load_count == CNT_W'(LOAD_DEPTH));
        fifo_empty = (load_count == '0);
        force_head = !fifo_empty && (fifo_full || (wait_q == WAIT_MAX));
        alu_ready  = !(fifo_full || (wait_q == WAIT_MAX));
        lsu_ready  = !fifo_full;
        grant      = GRANT_NONE;
        if (force_head) begin
            grant = GRANT_LOAD;
        end else if (bus.aluValid) begin
            grant = GRANT_ALU;
        end else if (!fifo_empty) begin
            grant = GRANT_LOAD;
        end
    end

    // Next write-port state and starvation counter; writes to x0 are consumed silently.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        case (grant)
            GRANT_ALU: begin
                we_d    = (bus.aluAddress != '0);
                waddr_d = bus.aluAddress;
                wdata_d = bus.aluData;
            end
            GRANT_LOAD: begin
                we_d    = (fifo_head.addr != '0);
                waddr_d = fifo_head.addr;
                wdata_d = fifo_head.data;
            end
            default: ;
        endcase
        if (fifo_empty || head_pop) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wait_q  <= wait_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Registers with a load still in flight; x0 never counts as pending.
    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 0; i < LOAD_DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending_mask = pending_mask | addr_onehot(entry_addr[i]);
            end
        end
        pending_mask[0] = 1'b0;
    end

    assign bus.aluReady     = alu_ready;
    assign bus.lsuReady     = lsu_ready;
    assign bus.writeEnable  = we_q;
    assign bus.writeAddress = waddr_q;
    assign bus.writeData    = wdata_q;
    assign bus.pendingMask  = pending_mask;
    assign bus.loadCount    = load_count;

endmodule
